// File: rtl/elevator_pkg.sv
// Shared types and defaults for the elevator car motion path.
package elevator_pkg;

  localparam int DEFAULT_NUM_FLOORS = 7;
  localparam int DEFAULT_FLOOR_W    = 3;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE   = 2'd1,
    ARRIVE = 2'd2,
    DOOR   = 2'd3
  } motion_state_t;

endpackage

// File: rtl/elevator_motion_controller_if.sv
// Bundle between the motion controller and the resolver/request-queue side.
interface elevator_motion_controller_if
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = DEFAULT_NUM_FLOORS,
  parameter int FLOOR_W    = DEFAULT_FLOOR_W
);

  logic [NUM_FLOORS-1:0] queue_status;
  logic                  queue_empty;
  logic                  next_up_ndown;
  logic [FLOOR_W-1:0]    current_floor;
  logic                  current_up_ndown;
  logic                  moving;
  logic                  door_open;
  logic                  served_valid;
  logic [FLOOR_W-1:0]    served_floor;

  modport master (
    input  queue_status,
    input  queue_empty,
    input  next_up_ndown,
    output current_floor,
    output current_up_ndown,
    output moving,
    output door_open,
    output served_valid,
    output served_floor
  );

  modport slave (
    output queue_status,
    output queue_empty,
    output next_up_ndown,
    input  current_floor,
    input  current_up_ndown,
    input  moving,
    input  door_open,
    input  served_valid,
    input  served_floor
  );

endinterface

// File: rtl/elevator_timer.sv
// Loadable down-counter that saturates at zero; shared by travel and door dwell.
module elevator_timer
  import elevator_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/elevator_motion_controller.sv
// Car motion FSM: sequences floor hops and door dwell, owns position/direction.
module elevator_motion_controller
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = DEFAULT_NUM_FLOORS,
  parameter int FLOOR_W       = DEFAULT_FLOOR_W,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 4,
  parameter int RESET_FLOOR   = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  elevator_motion_controller_if.master  bus
);

  localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TIMER_W    = $clog2(MAX_CYCLES + 1);

  localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [FLOOR_W-1:0] START_FLOOR = FLOOR_W'(RESET_FLOOR);
  // Door cycles to wait before the queue's clear of the served bit is visible.
  localparam logic [1:0]         DOOR_SETTLE = 2'd2;

  motion_state_t      state_q, state_d;
  logic [FLOOR_W-1:0] floor_q, floor_d;
  logic               dir_q, dir_d;
  logic               moving_q, moving_d;
  logic               door_q, door_d;
  logic               served_valid_q, served_valid_d;
  logic [FLOOR_W-1:0] served_floor_q, served_floor_d;
  logic [1:0]         door_age_q, door_age_d;

  logic               timer_load;
  logic [TIMER_W-1:0] timer_value;
  logic               timer_zero;

  logic               local_req;
  logic               move_dir;

  elevator_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .load_i       (timer_load),
    .load_value_i (timer_value),
    .zero_o       (timer_zero)
  );

  always_comb begin
    local_req = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (floor_q == FLOOR_W'(i)) begin
        local_req = bus.queue_status[i];
      end
    end
  end

  // Never head off the end of the shaft, whatever the resolver asks for.
  always_comb begin
    move_dir = bus.next_up_ndown;
    if (bus.next_up_ndown == DIR_UP && floor_q == TOP_FLOOR) begin
      move_dir = DIR_DOWN;
    end else if (bus.next_up_ndown == DIR_DOWN && floor_q == '0) begin
      move_dir = DIR_UP;
    end
  end

  always_comb begin
    state_d        = state_q;
    floor_d        = floor_q;
    dir_d          = dir_q;
    served_valid_d = 1'b0;
    served_floor_d = served_floor_q;
    door_age_d     = door_age_q;
    timer_load     = 1'b0;
    timer_value    = DOOR_LOAD;

    unique case (state_q)
      IDLE, ARRIVE: begin
        if (local_req) begin
          state_d        = DOOR;
          timer_load     = 1'b1;
          timer_value    = DOOR_LOAD;
          served_valid_d = 1'b1;
          served_floor_d = floor_q;
          door_age_d     = 2'd0;
        end else if (!bus.queue_empty) begin
          state_d     = MOVE;
          timer_load  = 1'b1;
          timer_value = TRAVEL_LOAD;
          dir_d       = move_dir;
        end else begin
          state_d = IDLE;
        end
      end

      MOVE: begin
        if (timer_zero) begin
          state_d = ARRIVE;
          floor_d = (dir_q == DIR_UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
        end
      end

      DOOR: begin
        if (door_age_q != DOOR_SETTLE) begin
          door_age_d = door_age_q + 2'd1;
        end
        if (door_age_q == DOOR_SETTLE && local_req) begin
          timer_load     = 1'b1;
          timer_value    = DOOR_LOAD;
          served_valid_d = 1'b1;
          served_floor_d = floor_q;
          door_age_d     = 2'd0;
        end else if (timer_zero) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    moving_d = (state_d == MOVE);
    door_d   = (state_d == DOOR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      floor_q        <= START_FLOOR;
      dir_q          <= DIR_UP;
      moving_q       <= 1'b0;
      door_q         <= 1'b0;
      served_valid_q <= 1'b0;
      served_floor_q <= '0;
      door_age_q     <= 2'd0;
    end else begin
      state_q        <= state_d;
      floor_q        <= floor_d;
      dir_q          <= dir_d;
      moving_q       <= moving_d;
      door_q         <= door_d;
      served_valid_q <= served_valid_d;
      served_floor_q <= served_floor_d;
      door_age_q     <= door_age_d;
    end
  end

  assign bus.current_floor    = floor_q;
  assign bus.current_up_ndown = dir_q;
  assign bus.moving           = moving_q;
  assign bus.door_open        = door_q;
  assign bus.served_valid     = served_valid_q;
  assign bus.served_floor     = served_floor_q;

endmodule

// File: tb/tb_elevator_motion_controller.sv
// Directed-vector bench for elevator_motion_controller with a small queue/resolver model.
module tb_elevator_motion_controller;

  localparam int NF = 7;
  localparam int FW = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  elevator_motion_controller_if #(.NUM_FLOORS(NF), .FLOOR_W(FW)) bus ();

  elevator_motion_controller #(
    .NUM_FLOORS    (NF),
    .FLOOR_W       (FW),
    .TRAVEL_CYCLES (8),
    .DOOR_CYCLES   (4),
    .RESET_FLOOR   (0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [NF-1:0] qs        = '0;
  logic          force_up  = 1'b0;
  logic          clr_pend  = 1'b0;
  logic [FW-1:0] clr_floor = '0;
  logic          above;
  int            vectors    = 0;
  int            miscompares = 0;

  // Resolver stand-in: head up only if something is pending above the car.
  always_comb begin
    above = 1'b0;
    for (int i = 0; i < NF; i++) begin
      if (i > int'(bus.current_floor) && qs[i]) above = 1'b1;
    end
  end

  assign bus.queue_status  = qs;
  assign bus.queue_empty   = (qs == '0);
  assign bus.next_up_ndown = force_up | above;

  // One clock; the queue clears a served bit one cycle after the pulse.
  task automatic tick();
    @(posedge clk);
    #1;
    if (clr_pend) qs[clr_floor] = 1'b0;
    clr_pend  = bus.served_valid;
    clr_floor = bus.served_floor;
  endtask

  task automatic test_reset();
    logic [9:0] got, exp;
    qs = '0; force_up = 1'b0; clr_pend = 1'b0;
    #2 reset = 1'b0;
    #2;
    got = {bus.current_floor, bus.current_up_ndown, bus.moving, bus.door_open, bus.served_valid, bus.served_floor};
    exp = {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL reset_state: got %b want %b", got, exp);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    $display("test_reset: reset values checked");
  endtask

  task automatic test_idle();
    logic [6:0] got, exp;
    qs = '0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      got = {bus.current_floor, bus.current_up_ndown, bus.moving, bus.door_open, bus.served_valid};
      exp = {3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL idle_k%0d: got %b want %b", k, got, exp);
      end
    end
    $display("test_idle: 50 empty cycles checked");
  endtask

  task automatic test_local_floor();
    logic [7:0] got, exp;
    qs = 7'b0000001;
    for (int k = 1; k <= 8; k++) begin
      tick();
      got = {bus.current_floor, bus.moving, bus.door_open, bus.served_valid, bus.served_floor};
      exp = {3'd0, 1'b0, (k <= 4), (k == 1), 3'd0};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL local_k%0d: got %b want %b", k, got, exp);
      end
    end
    $display("test_local_floor: door at floor 0 checked");
  endtask

  task automatic test_travel();
    logic [9:0] got, exp;
    logic [2:0] ef;
    qs = 7'b0001000;
    for (int k = 1; k <= 34; k++) begin
      tick();
      ef  = (k < 9) ? 3'd0 : (k < 18) ? 3'd1 : (k < 27) ? 3'd2 : 3'd3;
      got = {bus.current_floor, bus.current_up_ndown, bus.moving, bus.door_open, bus.served_valid, bus.served_floor};
      exp = {ef, 1'b1, (k < 27 && (k % 9) != 0), (k >= 28 && k <= 31), (k == 28), (k >= 28) ? 3'd3 : 3'd0};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL travel_k%0d: got %b want %b", k, got, exp);
      end
    end
    $display("test_travel: 0->3 with door checked");
  endtask

  task automatic test_hold_open();
    logic [7:0] got, exp;
    qs = 7'b0001000;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 3) qs[3] = 1'b1;
      got = {bus.current_floor, bus.moving, bus.door_open, bus.served_valid, bus.served_floor};
      exp = {3'd3, 1'b0, (k <= 7), (k == 1 || k == 4), 3'd3};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL hold_k%0d: got %b want %b", k, got, exp);
      end
    end
    $display("test_hold_open: door re-open at floor 3 checked");
  endtask

  task automatic test_boundary();
    logic [9:0] got, exp;
    logic [2:0] ef;
    qs = 7'b1000000;
    for (int k = 1; k <= 32; k++) begin
      tick();
      ef  = (k < 9) ? 3'd3 : (k < 18) ? 3'd4 : (k < 27) ? 3'd5 : 3'd6;
      got = {bus.current_floor, bus.current_up_ndown, bus.moving, bus.door_open, bus.served_valid, bus.served_floor};
      exp = {ef, 1'b1, (k < 27 && (k % 9) != 0), (k >= 28 && k <= 31), (k == 28), (k >= 28) ? 3'd6 : 3'd3};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL climb_k%0d: got %b want %b", k, got, exp);
      end
    end
    force_up = 1'b1;
    qs = 7'b0000100;
    for (int k = 1; k <= 41; k++) begin
      tick();
      if (k == 1) force_up = 1'b0;
      ef  = (k < 9) ? 3'd6 : (k < 18) ? 3'd5 : (k < 27) ? 3'd4 : (k < 36) ? 3'd3 : 3'd2;
      got = {bus.current_floor, bus.current_up_ndown, bus.moving, bus.door_open, bus.served_valid, bus.served_floor};
      exp = {ef, 1'b0, (k < 36 && (k % 9) != 0), (k >= 37 && k <= 40), (k == 37), (k >= 37) ? 3'd2 : 3'd6};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL descend_k%0d: got %b want %b", k, got, exp);
      end
    end
    $display("test_boundary: top-floor direction correction checked");
  endtask

  task automatic test_reset_mid_move();
    logic [9:0] got, exp;
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    clr_pend = 1'b0;
    qs = 7'b0000010;
    for (int k = 1; k <= 4; k++) begin
      tick();
      vectors++;
      if (bus.moving !== 1'b1) begin
        miscompares++;
        $display("FAIL premove_k%0d: got moving=%b want 1", k, bus.moving);
      end
    end
    #1 reset = 1'b0;
    #1;
    got = {bus.current_floor, bus.current_up_ndown, bus.moving, bus.door_open, bus.served_valid, bus.served_floor};
    exp = {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL abort_async: got %b want %b", got, exp);
    end
    clr_pend = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      got = {bus.current_floor, bus.current_up_ndown, bus.moving, bus.door_open, bus.served_valid, bus.served_floor};
      exp = {(k < 9) ? 3'd0 : 3'd1, 1'b1, (k < 9), (k >= 10), (k == 10), (k >= 10) ? 3'd1 : 3'd0};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL resume_k%0d: got %b want %b", k, got, exp);
      end
    end
    $display("test_reset_mid_move: abort and resume checked");
  endtask

  initial begin
    test_reset();
    test_idle();
    test_local_floor();
    test_travel();
    test_hold_open();
    test_boundary();
    test_reset_mid_move();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/elevator_motion_controller.md
Name: elevator_motion_controller

Overview:
Car motion FSM, directly downstream of elevator_direction_resolver. It consumes next_up_ndown and queue_empty from the resolver, plus queue_status from the request queue. It owns the registered current_floor and current_up_ndown that feed back into the resolver. It sequences travel between floors and door dwell, and emits a one-cycle "served" pulse so the request queue can clear the serviced floor bit.

Parameters:
NUM_FLOORS, 7, number of floors; queue_status width
FLOOR_W, 3, floor index width; must satisfy 2**FLOOR_W >= NUM_FLOORS
TRAVEL_CYCLES, 8, clock cycles spent in MOVE per floor hop; minimum 1
DOOR_CYCLES, 4, clock cycles door stays open; minimum 3
RESET_FLOOR, 0, floor loaded at reset

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
queue_status  input  NUM_FLOORS  pending-request bitmap, bit i = floor i
queue_empty  input  1  from resolver; 1 = no pending requests
next_up_ndown  input  1  from resolver; direction to take next (1 = up)
current_floor  output  FLOOR_W  registered car position
current_up_ndown  output  1  registered travel direction (1 = up)
moving  output  1  1 while state == MOVE
door_open  output  1  1 while state == DOOR
served_valid  output  1  one-cycle pulse: floor served
served_floor  output  FLOOR_W  floor being served; valid when served_valid = 1

Behaviour:
- Reset (reset low, asynchronous assert, synchronous-release by design):
  - state = IDLE, current_floor = RESET_FLOOR, current_up_ndown = 1.
  - moving = 0, door_open = 0, served_valid = 0, served_floor = 0, timer = 0.
  - A reset mid-MOVE or mid-DOOR aborts immediately; no served pulse is issued.
- States: IDLE, MOVE, ARRIVE, DOOR (enum in package). All outputs are registered.
- IDLE, evaluated each cycle in this priority order:
  1. queue_status[current_floor] = 1 -> DOOR; timer = DOOR_CYCLES-1; served_valid = 1, served_floor = current_floor, both on the first DOOR cycle.
  2. Else if queue_empty = 0 -> MOVE; timer = TRAVEL_CYCLES-1; current_up_ndown = next_up_ndown.
     - Boundary correction: if next_up_ndown = 1 at floor NUM_FLOORS-1, or next_up_ndown = 0 at floor 0, latch the inverted direction instead.
  3. Else stay in IDLE.
- MOVE:
  - timer decrements each cycle.
  - When timer = 0: current_floor +1 (up) or -1 (down), go to ARRIVE. Total MOVE dwell = TRAVEL_CYCLES cycles.
  - Floor never leaves 0..NUM_FLOORS-1; the boundary correction guarantees this.
- ARRIVE (exactly 1 cycle):
  - Same priority evaluation as IDLE, using the new floor.
  - If neither a local request nor a pending request exists -> IDLE.
  - Hop period is therefore TRAVEL_CYCLES+1 cycles.
- DOOR:
  - door_open = 1; timer decrements.
  - served_valid is high only in the first DOOR cycle.
  - The queue clears the bit in the following cycle, so queue_status[current_floor] is ignored during the first 2 DOOR cycles.
  - Hold-open: from the 3rd DOOR cycle onward, queue_status[current_floor] = 1 reloads timer = DOOR_CYCLES-1 and re-pulses served_valid in the next cycle.
  - When timer = 0 with no hold-open -> IDLE.
- Simultaneous request at the current floor and elsewhere: the current floor always wins (door first).
- queue_status bits at or above NUM_FLOORS are ignored.
- served_floor holds its last value when served_valid = 0.

Decomposition:
- elevator_pkg holds:
  - NUM_FLOORS and FLOOR_W defaults.
  - DIR_UP = 1'b1, DIR_DOWN = 1'b0.
  - motion_state_t enum {IDLE, MOVE, ARRIVE, DOOR}.
- Sub-module elevator_timer: loadable down-counter with load, load_value, and zero flag, on the same clk/reset. A single instance is shared by the MOVE and DOOR phases.

Test Plan:
1. Reset, then queue_status = 7'b0000000, queue_empty = 1 for 50 cycles -> current_floor = 0, current_up_ndown = 1, moving = 0, door_open = 0, served_valid never set.
2. At floor 0, queue_status = 7'b0001000, next_up_ndown = 1; bench clears the bit on served_valid ->
   - current_floor steps 0->1->2->3, one step every 9 cycles;
   - door_open high for 4 cycles;
   - exactly one served_valid with served_floor = 3, then IDLE.
3. Idle at floor 0, queue_status = 7'b0000001 -> DOOR on the next cycle, moving never set, served_floor = 0.
4. Car at floor 6, queue_status = 7'b0000100, next_up_ndown forced 1 -> current_up_ndown latches 0; car reaches floor 2 and never exceeds 6.
5. reset driven low during the 4th MOVE cycle of hop 0->1 -> outputs return to reset values immediately (same timestep, no clock edge), current_floor = 0; after release the car re-evaluates from IDLE.
6. At floor 3 with door open, bench re-asserts queue_status[3] in DOOR cycle 3 -> second served_valid pulse for floor 3; door_open stays high a total of 3+4 = 7 cycles.
